// File: rtl/rw_seq_pkg.sv
// rw_seq_pkg: state encodings and gap-draw helper shared by the strobe sequencer.
package rw_seq_pkg;
    typedef enum logic [1:0] {W_IDLE, W_STB, W_GAP, W_FIN} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ACT, R_FIN} rd_state_e;
    function automatic logic [7:0] gap_calc(input logic [7:0] lfsr_byte, input int gmin, input int gmax);
        return 8'(gmin + int'(lfsr_byte) % (gmax - gmin + 1));
    endfunction
endpackage

// File: rtl/rw_gap_lfsr.sv
// rw_gap_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) feeding the gap draws.
module rw_gap_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= SEED;
        else if (en) q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
endmodule

// File: rtl/rw_strobe_sequencer.sv
// rw_strobe_sequencer: concurrent wr/rd strobe generator with a one-cycle done pulse.
// RW_SEQ_LFSR_GAP_EN selects pseudorandom gaps; otherwise every gap is GAP_MAX.
module rw_strobe_sequencer
    import rw_seq_pkg::*;
#(
    parameter int          NUM_WR  = 5,
    parameter int          NUM_RD  = 5,
    parameter int          RD_LEN  = 2,
    parameter int          GAP_MIN = 1,
    parameter int          GAP_MAX = 3,
    parameter logic [15:0] SEED    = 16'hACE1,
    localparam int         WCW     = $clog2(NUM_WR + 1),
    localparam int         RCW     = $clog2(NUM_RD + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           wr,
    output logic           rd,
    output logic           done,
    output logic           busy,
    output logic [WCW-1:0] wr_cnt,
    output logic [RCW-1:0] rd_cnt
);
    localparam int CW = $clog2((GAP_MAX > RD_LEN ? GAP_MAX : RD_LEN) + 1);

    wr_state_e      r_wr_st, w_wr_nxt;
    rd_state_e      r_rd_st, w_rd_nxt;
    logic [CW-1:0]  r_wr_tmr, r_rd_tmr;
    logic [WCW-1:0] r_wr_cnt;
    logic [RCW-1:0] r_rd_cnt;
    logic [7:0]     w_wr_gap, w_rd_gap;
    logic           w_both_fin, w_go;

`ifdef RW_SEQ_LFSR_GAP_EN
    logic [15:0] w_lfsr;
    rw_gap_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .en(busy), .q(w_lfsr));
    // simultaneous draws must not share a byte, so read takes the upper half
    assign w_wr_gap = gap_calc(w_lfsr[7:0], GAP_MIN, GAP_MAX);
    assign w_rd_gap = gap_calc((r_wr_st == W_STB) ? w_lfsr[15:8] : w_lfsr[7:0], GAP_MIN, GAP_MAX);
`else
    logic w_unused;
    assign w_unused = ^{SEED, 32'(GAP_MIN)};
    assign w_wr_gap = 8'(GAP_MAX);
    assign w_rd_gap = 8'(GAP_MAX);
`endif

    assign w_both_fin = (r_wr_st == W_FIN) && (r_rd_st == R_FIN);
    assign busy       = (r_wr_st != W_IDLE) && !w_both_fin;
    assign done       = w_both_fin;
    assign w_go       = start && !busy;
    assign wr         = r_wr_st == W_STB;
    assign rd         = r_rd_st == R_ACT;
    assign wr_cnt     = r_wr_cnt;
    assign rd_cnt     = r_rd_cnt;

    always_comb begin
        w_wr_nxt = r_wr_st;
        unique case (r_wr_st)
            W_STB:   w_wr_nxt = W_GAP;
            W_GAP:   if (r_wr_tmr == '0) w_wr_nxt = (r_wr_cnt == WCW'(NUM_WR)) ? W_FIN : W_STB;
            default: w_wr_nxt = w_go ? W_STB : w_both_fin ? W_IDLE : r_wr_st;
        endcase
    end

    always_comb begin
        w_rd_nxt = r_rd_st;
        unique case (r_rd_st)
            R_WAIT:  if (r_rd_tmr == '0) w_rd_nxt = (r_rd_cnt == RCW'(NUM_RD)) ? R_FIN : R_ACT;
            R_ACT:   if (r_rd_tmr == '0) w_rd_nxt = R_WAIT;
            default: w_rd_nxt = w_go ? R_WAIT : w_both_fin ? R_IDLE : r_rd_st;
        endcase
    end

    // timers load on state entry and count down to zero, where the state exits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_st  <= W_IDLE;
            r_rd_st  <= R_IDLE;
            r_wr_tmr <= '0;
            r_rd_tmr <= '0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_wr_st  <= w_wr_nxt;
            r_rd_st  <= w_rd_nxt;
            r_wr_tmr <= (r_wr_st == W_STB) ? CW'(w_wr_gap - 8'd1) :
                        (r_wr_tmr != '0) ? r_wr_tmr - CW'(1) : r_wr_tmr;
            r_rd_tmr <= (w_rd_nxt == r_rd_st) ? ((r_rd_tmr != '0) ? r_rd_tmr - CW'(1) : r_rd_tmr) :
                        (w_rd_nxt == R_ACT) ? CW'(RD_LEN - 1) : CW'(w_rd_gap - 8'd1);
            r_wr_cnt <= w_go ? WCW'(1) :
                        (r_wr_st == W_GAP && w_wr_nxt == W_STB) ? r_wr_cnt + WCW'(1) : r_wr_cnt;
            r_rd_cnt <= w_go ? '0 :
                        (r_rd_st == R_WAIT && w_rd_nxt == R_ACT) ? r_rd_cnt + RCW'(1) : r_rd_cnt;
        end
    end
endmodule

// File: tb/tb_rw_strobe_sequencer.sv
// tb_rw_strobe_sequencer: timestamped scoreboard against an arithmetic schedule model,
// plus strobe invariant checks on the default instance when RW_SEQ_LFSR_GAP_EN is set.
module tb_rw_strobe_sequencer;
    typedef struct packed {logic wr, rd, done, busy; logic [3:0] wc, rc;} obs_t;
`ifdef RW_SEQ_LFSR_GAP_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif
    localparam int N_RUNS = RND ? 200 : 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mon_en = 1'b0;
    logic [2:0] start = '0;
    logic [2:0] wr, rd, done, busy;
    logic [2:0] wc0, rc0, wc1;
    logic [0:0] rc1, rc2;
    logic [1:0] wc2;
    int         cyc = 0, checks = 0, errors = 0;
    obs_t       exp_tab[int];
    obs_t       idle_exp[3];

    rw_strobe_sequencer u0 (.clk(clk), .rst(rst), .start(start[0]), .wr(wr[0]), .rd(rd[0]),
        .done(done[0]), .busy(busy[0]), .wr_cnt(wc0), .rd_cnt(rc0));
    rw_strobe_sequencer #(.NUM_RD(1), .RD_LEN(4), .GAP_MIN(1), .GAP_MAX(1)) u1 (.clk(clk), .rst(rst),
        .start(start[1]), .wr(wr[1]), .rd(rd[1]), .done(done[1]), .busy(busy[1]), .wr_cnt(wc1), .rd_cnt(rc1));
    rw_strobe_sequencer #(.NUM_WR(2), .NUM_RD(1), .RD_LEN(2), .GAP_MIN(1), .GAP_MAX(1)) u2 (.clk(clk), .rst(rst),
        .start(start[2]), .wr(wr[2]), .rd(rd[2]), .done(done[2]), .busy(busy[2]), .wr_cnt(wc2), .rd_cnt(rc2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t act(input int id);
        case (id)
            0:       return {wr[0], rd[0], done[0], busy[0], 4'(wc0), 4'(rc0)};
            1:       return {wr[1], rd[1], done[1], busy[1], 4'(wc1), 4'(rc1)};
            default: return {wr[2], rd[2], done[2], busy[2], 4'(wc2), 4'(rc2)};
        endcase
    endfunction

    task automatic check_o(input string nm, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got wr=%b rd=%b done=%b busy=%b wc=%0d rc=%0d, expected wr=%b rd=%b done=%b busy=%b wc=%0d rc=%0d",
                nm, cyc, a.wr, a.rd, a.done, a.busy, a.wc, a.rc, e.wr, e.rd, e.done, e.busy, e.wc, e.rc);
        end
    endtask

    task automatic check_i(input string nm, input int a, input int lo, input int hi);
        checks++;
        if (a < lo || a > hi) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d, expected %0d..%0d", nm, cyc, a, lo, hi);
        end
    endtask

    task automatic cfg(input int id, output int w, output int r, output int l, output int g);
        w = (id == 2) ? 2 : 5;
        r = (id == 0) ? 5 : 1;
        l = (id == 1) ? 4 : 2;
        g = (id == 0) ? 3 : 1;
    endtask

    // schedule for one run with fixed gap g: wr every g+1 cycles, rd pulses every g+l after g idle cycles
    task automatic push_run(input int id, input int base, output int d);
        int w, r, l, g, p, q, j;
        obs_t o;
        cfg(id, w, r, l, g);
        p = 1 + g;
        q = g + l;
        d = (w * p + 1 > r * q + g + 1) ? w * p + 1 : r * q + g + 1;
        for (int k = 1; k <= d; k++) begin
            j = k - 1 - g;
            o.wr   = (k <= w * p) && ((k - 1) % p == 0);
            o.rd   = (j >= 0) && (j < r * q) && (j % q < l);
            o.done = k == d;
            o.busy = k < d;
            o.wc   = 4'(((k - 1) / p + 1 < w) ? (k - 1) / p + 1 : w);
            o.rc   = 4'((j < 0) ? 0 : (j / q + 1 < r) ? j / q + 1 : r);
            exp_tab[(base + k) * 4 + id] = o;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int id, input int hold, input int idle);
        int base, d, t0;
        base = cyc;
        start[id] = 1'b1;
        if (RND && id == 0) begin
            wait_cyc(base + 1);
            start[id] = 1'b0;
            t0 = cyc;
            while (!done[0] && cyc < t0 + 200) begin
                @(posedge clk);
                #1;
            end
            check_i("u0 done seen", int'(done[0]), 1, 1);
            wait_cyc(cyc + idle);
        end else begin
            push_run(id, base, d);
            wait_cyc(base + ((hold < d) ? hold : d));
            start[id] = 1'b0;
            wait_cyc(base + d + idle);
        end
    endtask

    always @(negedge clk) begin
        int   key;
        obs_t e;
        if (mon_en) begin
            for (int id = 0; id < 3; id++) begin
                key = cyc * 4 + id;
                if (exp_tab.exists(key)) begin
                    e = exp_tab[key];
                    exp_tab.delete(key);
                    check_o($sformatf("u%0d trace", id), act(id), e);
                    if (e.done) idle_exp[id] = {4'b0, e.wc, e.rc};
                end else if (!(RND && id == 0)) begin
                    check_o($sformatf("u%0d idle", id), act(id), idle_exp[id]);
                end
            end
        end
    end

`ifdef RW_SEQ_LFSR_GAP_EN
    int   wl, rl, rh, wn, rn;
    logic pw, pr;
    always @(negedge clk) begin
        if (!rst) begin
            wl = 0; rl = 0; rh = 0; wn = 0; rn = 0; pw = 1'b0; pr = 1'b0;
        end else if (mon_en) begin
            if (wr[0]) begin
                check_i("u0 wr width", int'(pw), 0, 0);
                if (wn > 0) check_i("u0 wr gap", wl, 1, 3);
                wn++;
                wl = 0;
            end else wl++;
            if (rd[0]) begin
                if (!pr && rn > 0) check_i("u0 rd gap", rl, 1, 3);
                if (!pr) rn++;
                rh++;
            end else begin
                if (pr) begin
                    check_i("u0 rd width", rh, 2, 2);
                    rh = 0;
                    rl = 0;
                end
                rl++;
            end
            if (done[0]) begin
                check_i("u0 wr rises", wn, 5, 5);
                check_i("u0 rd rises", rn, 5, 5);
                check_i("u0 done after rd fall", rl, 2, 1000);
                wn = 0; rn = 0; wl = 0; rl = 0;
            end
            pw = wr[0];
            pr = rd[0];
        end
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d;
        for (int i = 0; i < 3; i++) idle_exp[i] = '0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_o($sformatf("u%0d reset state", i), act(i), '0);
        rst = 1'b1;
        mon_en = 1'b1;
        wait_cyc(cyc + 2);
        // default config, single start pulse
        run(0, 1, 3);
        // start held through three back-to-back runs
        base = cyc;
        start[1] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push_run(1, base, d);
            base += d;
        end
        wait_cyc(base);
        start[1] = 1'b0;
        wait_cyc(base + 3);
        // long rd pulse, and both channels finishing together
        run(1, 1, 2);
        run(2, 1, 2);
        // reset mid-run at T+11
        base = cyc;
        start[0] = 1'b1;
        if (!RND) push_run(0, base, d);
        wait_cyc(base + 1);
        start[0] = 1'b0;
        wait_cyc(base + 11);
        check_i("u0 busy before mid-run reset", int'(busy[0]), 1, 1);
        exp_tab.delete();
        for (int i = 0; i < 3; i++) idle_exp[i] = '0;
        rst = 1'b0;
        #1;
        check_o("u0 mid-run reset", act(0), '0);
        wait_cyc(base + 14);
        rst = 1'b1;
        wait_cyc(cyc + 2);
        run(0, 1, 2);
        // randomized runs with random start hold lengths and idle spacing
        for (int n = 0; n < N_RUNS; n++)
            run(int'($urandom_range(0, 2)), int'($urandom_range(1, 40)), int'($urandom_range(0, 3)));
        wait_cyc(cyc + 3);
        check_i("scoreboard drained", exp_tab.size(), 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
